// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, reads a same-cycle instruction memory and
// hands words to decode through a one-entry valid/ready register. Optional halt-on-zero: FETCH_HALT_ON_ZERO_EN.
module fetch_sequencer #(
  parameter int                        address_length = 3,
  parameter logic [address_length-1:0] RESET_PC       = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic [address_length-1:0] imem_address,
  input  logic [31:0]               imem_data,
  output logic                      inst_valid,
  input  logic                      inst_ready,
  output logic [31:0]               inst_data,
  output logic [address_length-1:0] inst_pc,
  input  logic                      redirect_valid,
  input  logic [address_length-1:0] redirect_target,
  output logic                      halted
);

  // Handshake: a word moves to decode on any rising edge where inst_valid && inst_ready;
  // inst_valid/inst_data/inst_pc are stable while inst_valid && !inst_ready.
  typedef enum logic {FETCH = 1'b0, HALT = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic [address_length-1:0] pc_q, pc_d;
  logic [address_length-1:0] inst_pc_q, inst_pc_d;
  logic [31:0]               inst_data_q, inst_data_d;
  logic                      inst_valid_q, inst_valid_d;
  logic                      halted_q, halted_d;
  logic                      transfer, reg_free, halt_word;

  assign transfer = inst_valid_q && inst_ready;
  assign reg_free = !inst_valid_q || transfer;

`ifdef FETCH_HALT_ON_ZERO_EN
  assign halt_word = (imem_data == 32'b0);
`else
  assign halt_word = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_pc_d    = inst_pc_q;
    inst_data_d  = inst_data_q;
    inst_valid_d = inst_valid_q;
    halted_d     = halted_q;
    if (redirect_valid) begin
      // Any transfer this cycle still completes; only the refill is dropped.
      pc_d         = redirect_target;
      inst_valid_d = 1'b0;
      state_d      = FETCH;
      halted_d     = 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (reg_free) begin
            if (halt_word) begin
              state_d      = HALT;
              halted_d     = 1'b1;
              inst_valid_d = 1'b0;
            end else begin
              inst_data_d  = imem_data;
              inst_pc_d    = pc_q;
              inst_valid_d = 1'b1;
              pc_d         = pc_q + 1'b1;
            end
          end
        end
        HALT: begin
          if (transfer) inst_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      inst_pc_q    <= '0;
      inst_data_q  <= '0;
      inst_valid_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_pc_q    <= inst_pc_d;
      inst_data_q  <= inst_data_d;
      inst_valid_q <= inst_valid_d;
      halted_q     <= halted_d;
    end
  end

  assign imem_address = pc_q;
  assign inst_valid   = inst_valid_q;
  assign inst_data    = inst_data_q;
  assign inst_pc      = inst_pc_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: stimulus pushes expected {pc, word} transfers into a
// queue; a negedge monitor pops and compares every handshake. Covers halt when FETCH_HALT_ON_ZERO_EN is set.
module tb_fetch_sequencer;
  localparam int AW = 3;
  localparam int W  = AW + 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] imem_address;
  logic [31:0]   imem_data;
  logic          inst_valid;
  logic          inst_ready;
  logic [31:0]   inst_data;
  logic [AW-1:0] inst_pc;
  logic          redirect_valid;
  logic [AW-1:0] redirect_target;
  logic          halted;

  logic [31:0]   mem [8];
  logic [W-1:0]  exp_q[$];
  int            n_vec  = 0;
  int            n_miss = 0;

  // Clock and reset
  always #5 clk = ~clk;

  fetch_sequencer #(.address_length(AW), .RESET_PC('0)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_address   (imem_address),
    .imem_data      (imem_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .halted         (halted)
  );

  assign imem_data = mem[imem_address];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic cyc(input logic r, input logic rv, input logic [AW-1:0] tgt);
    @(posedge clk);
    #1;
    inst_ready      = r;
    redirect_valid  = rv;
    redirect_target = tgt;
  endtask

  task automatic push(input logic [AW-1:0] pc, input logic [31:0] word);
    exp_q.push_back({pc, word});
  endtask

  // Scoreboard monitor: a handshake seen at negedge completes on the next rising edge
  always @(negedge clk) begin
    if (!reset && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) chk("unexpected_transfer", {inst_pc, inst_data}, '0);
      else chk("transfer", {inst_pc, inst_data}, exp_q.pop_front());
    end
  end

  initial begin
    mem[0] = 32'h2C00000A; mem[1] = 32'h2C010001; mem[2] = 32'h08210001; mem[3] = 32'h18017FFF;
    mem[4] = 32'h00000000; mem[5] = 32'h33330005; mem[6] = 32'h11110006; mem[7] = 32'h22220007;
    reset = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_target = '0;

    // Hand-computed transfer order
    push(0, 32'h2C00000A); push(1, 32'h2C010001); push(2, 32'h08210001); push(3, 32'h18017FFF);
    push(2, 32'h08210001);
    push(6, 32'h11110006); push(7, 32'h22220007); push(0, 32'h2C00000A); push(1, 32'h2C010001);
    push(3, 32'h18017FFF);
`ifndef FETCH_HALT_ON_ZERO_EN
    push(4, 32'h00000000);
`endif
    push(0, 32'h2C00000A); push(1, 32'h2C010001);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid",  W'(inst_valid), W'(0));
    chk("rst_data",   W'(inst_data), W'(0));
    chk("rst_pc",     W'(inst_pc), W'(0));
    chk("rst_addr",   W'(imem_address), W'(0));
    chk("rst_halted", W'(halted), W'(0));
    reset = 1'b0;

    cyc(1, 0, 0);
    @(negedge clk);
    chk("first_valid", W'({inst_valid, inst_pc}), W'({1'b1, 3'd0}));
    cyc(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_data", W'({inst_valid, inst_data}), W'({1'b1, 32'h2C010001}));
      chk("stall_addr", W'({inst_pc, imem_address}), W'({3'd1, 3'd2}));
      cyc((i == 2) ? 1'b1 : 1'b0, 0, 0);
    end
    cyc(1, 0, 0);
    @(negedge clk);
    chk("after_stall_pc", W'(inst_pc), W'(2));

    cyc(1, 1, 2);
    cyc(1, 0, 0);
    @(negedge clk);
    chk("redir_flush", W'({inst_valid, imem_address}), W'({1'b0, 3'd2}));
    cyc(1, 1, 6);
    @(negedge clk);
    chk("redir_word", W'({inst_valid, inst_pc, inst_data}), W'({1'b1, 3'd2, 32'h08210001}));

    // Redirect to 6 then wrap 7 -> 0; then back-to-back redirects (5 then 3)
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 1, 5);
    cyc(1, 1, 3);
    cyc(1, 0, 0);
    @(negedge clk);
    chk("b2b_redir", W'({inst_valid, imem_address}), W'({1'b0, 3'd3}));
    cyc(1, 0, 0);

`ifdef FETCH_HALT_ON_ZERO_EN
    cyc(1, 0, 0);
    @(negedge clk);
    chk("halt_enter", W'({halted, inst_valid, imem_address}), W'({1'b1, 1'b0, 3'd4}));
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    @(negedge clk);
    chk("halt_hold", W'({halted, inst_valid, imem_address}), W'({1'b1, 1'b0, 3'd4}));
    cyc(1, 0, 0);
    @(negedge clk);
    chk("halt_exit", W'({halted, inst_valid, imem_address}), W'({1'b0, 1'b0, 3'd0}));
    cyc(0, 0, 0);
    @(negedge clk);
    chk("halt_refetch", W'({inst_valid, inst_pc, inst_data}), W'({1'b1, 3'd0, 32'h2C00000A}));
`else
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    @(negedge clk);
    chk("nop_not_halt", W'({halted, inst_valid, inst_pc}), W'({1'b0, 1'b1, 3'd5}));
`endif

    // Asynchronous reset between edges, with a word pending
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst", W'({inst_valid, imem_address, halted}), W'({1'b0, 3'd0, 1'b0}));
    @(posedge clk);
    #1;
    reset = 1'b0;
    inst_ready = 1'b1;
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", W'(exp_q.size()), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
